// File: rtl/rs232c_pkg.sv
// rs232c_pkg
//   Types and constants shared by the RS-232C receiver and transmitter.
//   rx_state_t  : receiver frame FSM states
//   DEFAULT_BIT : idle line level
//   START_BIT   : start bit level
//   END_BIT     : stop bit level
//   half_period : mid-bit offset for a latched period value
package rs232c_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam logic DEFAULT_BIT = 1'b1;
  localparam logic START_BIT   = 1'b0;
  localparam logic END_BIT     = 1'b1;

  // (per+1)>>1 computed at 33 bits so per = 32'hFFFF_FFFF cannot wrap to 0.
  function automatic logic [31:0] half_period(input logic [31:0] per);
    logic [32:0] sum;
    sum = {1'b0, per} + 33'd1;
    return sum[32:1];
  endfunction

endpackage

// File: rtl/rs232c_rx_sync.sv
// rs232c_rx_sync
//   Synchronises the asynchronous serial line into the clk domain and
//   flags start-bit candidates.
//   clk    in  system clock
//   rst    in  asynchronous reset, active-high
//   rxd    in  raw serial line, async to clk
//   rxd_s  out synchronised line level
//   fall   out high for one cycle when rxd_s goes 1 -> 0
module rs232c_rx_sync
  import rs232c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic rxd_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s_d;

  // Reset to the idle level so leaving reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{DEFAULT_BIT}};
      rxd_s_d <= DEFAULT_BIT;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rxd};
      rxd_s_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rxd_s = sync_q[SYNC_STAGES-1];
  // Requiring the previous level high means a stuck-low line cannot retrigger.
  assign fall  = rxd_s_d & ~rxd_s;

endmodule

// File: rtl/rs232c_receiver.sv
// rs232c_receiver
//   UART receiver: 1 start bit, BIT_WIDTH data bits LSB-first, 1 stop bit.
//   Bit period is max_count+1 clk cycles, latched at frame start.
//   clk        in  system clock
//   rst        in  asynchronous reset, active-high
//   rxd        in  serial line, idle high, async to clk
//   max_count  in  bit period - 1 (>= 3)
//   recv_data  out last correctly framed word, held until the next one
//   r_valid    out 1-cycle pulse when recv_data is updated
//   frame_err  out 1-cycle pulse when the stop bit was sampled low
//   r_busy     out high while a frame is in progress
module rs232c_receiver
  import rs232c_pkg::*;
#(
  parameter int BIT_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic [31:0]          max_count,
  output logic [BIT_WIDTH-1:0] recv_data,
  output logic                 r_valid,
  output logic                 frame_err,
  output logic                 r_busy
);

  localparam int                IDX_W    = $clog2(BIT_WIDTH + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BIT_WIDTH - 1);

  rx_state_t             state;
  logic [31:0]           count;
  logic [31:0]           per_q;
  logic [31:0]           half;
  logic [IDX_W-1:0]      bit_idx;
  logic [BIT_WIDTH-1:0]  shreg;
  logic [BIT_WIDTH-1:0]  sh_next;
  logic                  rxd_s;
  logic                  fall;

  rs232c_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .rxd   (rxd),
    .rxd_s (rxd_s),
    .fall  (fall)
  );

  assign half = half_period(per_q);

  // New bit enters at the MSB; after BIT_WIDTH shifts the first bit is at bit 0.
  assign sh_next = (shreg >> 1) | (BIT_WIDTH'(rxd_s) << (BIT_WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      per_q     <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      recv_data <= '0;
      r_valid   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            count <= '0;
            per_q <= max_count;
          end
        end
        // Re-check the line at mid start bit to reject short glitches.
        START: begin
          if (count == half) begin
            count   <= '0;
            bit_idx <= '0;
            state   <= (rxd_s == START_BIT) ? DATA : IDLE;
          end else begin
            count <= count + 32'd1;
          end
        end
        // count restarts at 0 on the mid-start sample, so count==per_q lands mid-bit.
        DATA: begin
          if (count == per_q) begin
            shreg   <= sh_next;
            count   <= '0;
            bit_idx <= bit_idx + IDX_W'(1);
            if (bit_idx == LAST_IDX) state <= STOP;
          end else begin
            count <= count + 32'd1;
          end
        end
        // Leaving at mid stop bit lets a back-to-back start edge be caught.
        STOP: begin
          if (count == per_q) begin
            count <= '0;
            state <= IDLE;
            if (rxd_s == END_BIT) begin
              recv_data <= shreg;
              r_valid   <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            count <= count + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign r_busy = (state != IDLE);

endmodule
